// File: rtl/htif_bridge_pkg.sv
// Shared constants and FSM encodings for the host-interface bridge.
package htif_bridge_pkg;

    localparam int HTIF_XLEN   = 32;
    localparam int HTIF_BYTE_W = 8;
    localparam int HTIF_NBYTES = HTIF_XLEN / HTIF_BYTE_W;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SEND  = 2'd1,
        TX_CLEAR = 2'd2
    } tx_state_e;

    typedef enum logic {
        RX_COLLECT = 1'b0,
        RX_DELIVER = 1'b1
    } rx_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/htif_tx_shifter.sv
// TOHOST capture and byte serialiser: one shift register plus a single pending slot.
// state    | meaning
// TX_IDLE  | no word in flight; accepts a new word or drains the pending slot
// TX_SEND  | presenting bytes little-endian on the valid/ready link
// TX_CLEAR | one-cycle tohost_clr pulse for the word just sent
module htif_tx_shifter
    import htif_bridge_pkg::*;
#(
    parameter int XLEN   = HTIF_XLEN,
    parameter int BYTE_W = HTIF_BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tohost_we,
    input  logic [XLEN-1:0]   tohost_data,
    output logic              tohost_clr,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              overrun
);

    localparam int NBYTES = XLEN / BYTE_W;
    localparam int CNT_W  = cnt_width(NBYTES);

    tx_state_e         state_q, state_d;
    logic [XLEN-1:0]   shift_q;
    logic [XLEN-1:0]   pend_q;
    logic              pend_full_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              overrun_q;

    logic capture, last_byte;
    logic load_new, load_pend, to_pend, drop, shift_en;

    assign capture   = tohost_we && (tohost_data != '0);
    assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));
    assign tx_data   = shift_q[BYTE_W-1:0];
    assign overrun   = overrun_q;

    always_comb begin
        state_d    = state_q;
        load_new   = 1'b0;
        load_pend  = 1'b0;
        to_pend    = 1'b0;
        drop       = 1'b0;
        shift_en   = 1'b0;
        tx_valid   = 1'b0;
        tohost_clr = 1'b0;
        case (state_q)
            TX_IDLE: begin
                // Older pending word goes first; a same-cycle write refills the slot.
                if (pend_full_q) begin
                    load_pend = 1'b1;
                    to_pend   = capture;
                    state_d   = TX_SEND;
                end else if (capture) begin
                    load_new = 1'b1;
                    state_d  = TX_SEND;
                end
            end
            TX_SEND: begin
                tx_valid = 1'b1;
                to_pend  = capture && !pend_full_q;
                drop     = capture && pend_full_q;
                if (tx_ready) begin
                    shift_en = 1'b1;
                    if (last_byte) begin
                        state_d = TX_CLEAR;
                    end
                end
            end
            TX_CLEAR: begin
                tohost_clr = 1'b1;
                to_pend    = capture && !pend_full_q;
                drop       = capture && pend_full_q;
                state_d    = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= TX_IDLE;
            shift_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_pend) begin
                shift_q <= pend_q;
                cnt_q   <= '0;
            end else if (load_new) begin
                shift_q <= tohost_data;
                cnt_q   <= '0;
            end else if (shift_en) begin
                shift_q <= shift_q >> BYTE_W;
                cnt_q   <= last_byte ? '0 : cnt_q + 1'b1;
            end
            if (to_pend) begin
                pend_q      <= tohost_data;
                pend_full_q <= 1'b1;
            end else if (load_pend) begin
                pend_full_q <= 1'b0;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/htif_bridge.sv
// Host-interface bridge between the PCR file's TOHOST/FROMHOST registers and a byte-wide host link.
// state      | meaning
// RX_COLLECT | accepting host bytes into the assembly register
// RX_DELIVER | full word offered to FROMHOST until acked
module htif_bridge
    import htif_bridge_pkg::*;
#(
    parameter int XLEN   = HTIF_XLEN,
    parameter int BYTE_W = HTIF_BYTE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tohost_we,
    input  logic [XLEN-1:0]   tohost_data,
    output logic              tohost_clr,
    output logic              fromhost_we,
    output logic [XLEN-1:0]   fromhost_wdata,
    input  logic              fromhost_ack,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              overrun
);

    localparam int NBYTES = XLEN / BYTE_W;
    localparam int CNT_W  = cnt_width(NBYTES);

    htif_tx_shifter #(
        .XLEN   (XLEN),
        .BYTE_W (BYTE_W)
    ) u_tx (
        .clk         (clk),
        .reset       (reset),
        .tohost_we   (tohost_we),
        .tohost_data (tohost_data),
        .tohost_clr  (tohost_clr),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .overrun     (overrun)
    );

    rx_state_e        rx_state_q, rx_state_d;
    logic [XLEN-1:0]  rx_word_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic             rx_take, rx_last;

    assign rx_last        = (rx_cnt_q == CNT_W'(NBYTES - 1));
    assign fromhost_wdata = rx_word_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_ready    = 1'b0;
        rx_take     = 1'b0;
        fromhost_we = 1'b0;
        case (rx_state_q)
            RX_COLLECT: begin
                // Held low during reset so every output reads zero.
                rx_ready = !reset;
                rx_take  = rx_valid && !reset;
                if (rx_take && rx_last) begin
                    rx_state_d = RX_DELIVER;
                end
            end
            RX_DELIVER: begin
                fromhost_we = 1'b1;
                if (fromhost_ack) begin
                    rx_state_d = RX_COLLECT;
                end
            end
            default: rx_state_d = RX_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= RX_COLLECT;
            rx_word_q  <= '0;
            rx_cnt_q   <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            if (rx_take) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (rx_cnt_q == CNT_W'(i)) begin
                        rx_word_q[i*BYTE_W +: BYTE_W] <= rx_data;
                    end
                end
                rx_cnt_q <= rx_last ? '0 : rx_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_htif_bridge.sv
// Directed and randomized checks of htif_bridge against a word-queue reference model.
module tb_htif_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        tohost_we;
    logic [31:0] tohost_data;
    logic        tohost_clr;
    logic        fromhost_we;
    logic [31:0] fromhost_wdata;
    logic        fromhost_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        overrun;

    htif_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .tohost_we      (tohost_we),
        .tohost_data    (tohost_data),
        .tohost_clr     (tohost_clr),
        .fromhost_we    (fromhost_we),
        .fromhost_wdata (fromhost_wdata),
        .fromhost_ack   (fromhost_ack),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: accepted TOHOST words (head in service, at most one waiting).
    logic [31:0] m_q[$];
    int          m_b;
    bit          m_clr_due;
    bit          m_ovr;
    int          m_gap;
    bit          m_stall;
    logic [7:0]  m_prev_data;
    logic [31:0] m_rx_word;
    int          m_rx_cnt;
    bit          m_dlv;

    int          hs_cyc[$];
    logic [7:0]  hs_byte[$];
    int          clr_cyc[$];
    logic [31:0] fh_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_b = 0; m_clr_due = 0; m_ovr = 0; m_gap = 0; m_stall = 0; m_prev_data = '0;
        m_rx_word = '0; m_rx_cnt = 0; m_dlv = 0;
    endtask

    task automatic clear_logs();
        hs_cyc.delete(); hs_byte.delete(); clr_cyc.delete(); fh_log.delete();
    endtask

    task automatic monitor();
        logic [31:0] w;
        bit          new_clr;
        chk("tohost_clr", tohost_clr, m_clr_due);
        chk("overrun", overrun, m_ovr);
        chk("rx_ready", rx_ready, !m_dlv && !reset);
        chk("fromhost_we", fromhost_we, m_dlv);
        if (m_dlv) chk("fromhost_wdata", fromhost_wdata, m_rx_word);
        if (m_clr_due) chk("tx_valid_during_clr", tx_valid, 1'b0);
        if (tx_valid) chk("tx_valid_has_word", m_q.size() != 0, 1'b1);
        if (m_stall) begin
            chk("tx_hold_valid", tx_valid, 1'b1);
            chk("tx_hold_data", tx_data, m_prev_data);
        end
        if (tx_valid && tx_ready && m_q.size() != 0) begin
            w = m_q[0];
            chk("tx_byte", tx_data, w[8*m_b +: 8]);
        end
        if (m_q.size() != 0) begin
            if (!m_clr_due && !tx_valid) m_gap++;
            else m_gap = 0;
            chk("tx_start_gap", m_gap <= 1, 1'b1);
        end else begin
            m_gap = 0;
        end
        if (reset) begin
            model_reset();
            return;
        end
        if (tx_valid && tx_ready) begin
            hs_cyc.push_back(cyc);
            hs_byte.push_back(tx_data);
        end
        if (tohost_clr) clr_cyc.push_back(cyc);
        if (fromhost_we && fromhost_ack) fh_log.push_back(fromhost_wdata);

        new_clr = 0;
        if (tx_valid && tx_ready && m_q.size() != 0) begin
            m_b++;
            if (m_b == 4) new_clr = 1;
        end
        if (tohost_we && tohost_data != 0) begin
            if (m_q.size() < 2) m_q.push_back(tohost_data);
            else m_ovr = 1;
        end
        if (m_clr_due) begin
            void'(m_q.pop_front());
            m_b = 0;
        end
        m_clr_due   = new_clr;
        m_stall     = tx_valid && !tx_ready;
        m_prev_data = tx_data;

        if (m_dlv) begin
            if (fromhost_ack) m_dlv = 0;
        end else if (rx_valid) begin
            m_rx_word[8*m_rx_cnt +: 8] = rx_data;
            m_rx_cnt++;
            if (m_rx_cnt == 4) begin
                m_rx_cnt = 0;
                m_dlv    = 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [7:0]  t1_bytes[4];
        logic [7:0]  t3_bytes[8];
        logic [7:0]  t5_bytes[4];
        logic [7:0]  t6_rx[4];
        logic [7:0]  t6_bytes[4];
        logic [3:0]  pat;
        int          c0;

        t1_bytes = '{8'h44, 8'h33, 8'h22, 8'h11};
        t3_bytes = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h00};
        t5_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        t6_rx    = '{8'h10, 8'h20, 8'h30, 8'h40};
        t6_bytes = '{8'hCC, 8'hBB, 8'hAA, 8'h99};
        pat      = 4'b1001;

        reset = 1'b1; tohost_we = 0; tohost_data = '0; fromhost_ack = 0;
        tx_ready = 0; rx_data = '0; rx_valid = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_rx_ready", rx_ready, 1'b0);
        chk("reset_fromhost_wdata", fromhost_wdata, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Single word, no backpressure.
        clear_logs();
        tx_ready = 1; tohost_we = 1; tohost_data = 32'h11223344; c0 = cyc;
        tick();
        tohost_we = 0;
        repeat (7) tick();
        chk("t1_hs_count", hs_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < hs_cyc.size()) begin
                chk("t1_hs_cycle", hs_cyc[i], c0 + 1 + i);
                chk("t1_hs_byte", hs_byte[i], t1_bytes[i]);
            end
        end
        chk("t1_clr_count", clr_cyc.size(), 1);
        if (clr_cyc.size() > 0) chk("t1_clr_cycle", clr_cyc[0], c0 + 5);
        chk("t1_overrun", overrun, 1'b0);

        // Backpressure pattern 1,0,0,1.
        clear_logs();
        for (int i = 0; i < 20; i++) begin
            tx_ready    = pat[i % 4];
            tohost_we   = (i == 0);
            tohost_data = 32'h11223344;
            tick();
        end
        tohost_we = 0;
        chk("t2_hs_count", hs_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < hs_byte.size()) chk("t2_hs_byte", hs_byte[i], t1_bytes[i]);
        end
        chk("t2_clr_count", clr_cyc.size(), 1);

        // Zero write ignored.
        clear_logs();
        tx_ready = 1; tohost_we = 1; tohost_data = 32'h0;
        tick();
        tohost_we = 0;
        repeat (6) tick();
        chk("t4_hs_count", hs_cyc.size(), 0);
        chk("t4_clr_count", clr_cyc.size(), 0);

        // RX word with delayed ack.
        clear_logs();
        rx_valid = 1; fromhost_ack = 0;
        for (int i = 0; i < 4; i++) begin
            rx_data = t5_bytes[i];
            tick();
        end
        rx_valid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_fromhost_we", fromhost_we, 1'b1);
            chk("t5_wdata", fromhost_wdata, 32'hDEADBEEF);
            chk("t5_rx_ready_low", rx_ready, 1'b0);
            fromhost_ack = (i == 3);
            tick();
        end
        fromhost_ack = 0;
        chk("t5_we_dropped", fromhost_we, 1'b0);
        chk("t5_rx_ready_back", rx_ready, 1'b1);

        // Three writes while busy: third dropped.
        clear_logs();
        tx_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tohost_we   = 1;
            tohost_data = 32'hA + i;
            tick();
        end
        tohost_we = 0;
        repeat (16) tick();
        chk("t3_hs_count", hs_byte.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < hs_byte.size()) chk("t3_hs_byte", hs_byte[i], t3_bytes[i]);
        end
        chk("t3_clr_count", clr_cyc.size(), 2);
        chk("t3_overrun", overrun, 1'b1);
        repeat (5) tick();
        chk("t3_overrun_sticky", overrun, 1'b1);

        // Reset mid-transfer on both sides.
        clear_logs();
        tx_ready = 1; tohost_we = 1; tohost_data = 32'h55667788;
        rx_valid = 1; rx_data = 8'h01;
        tick();
        tohost_we = 0; rx_data = 8'h02;
        tick();
        rx_valid = 0;
        tick();
        reset = 1;
        tick();
        chk("t6_rst_tx_valid", tx_valid, 1'b0);
        chk("t6_rst_tx_data", tx_data, 8'h00);
        chk("t6_rst_clr", tohost_clr, 1'b0);
        chk("t6_rst_fh_we", fromhost_we, 1'b0);
        chk("t6_rst_fh_wdata", fromhost_wdata, 32'h0);
        chk("t6_rst_rx_ready", rx_ready, 1'b0);
        chk("t6_rst_overrun", overrun, 1'b0);
        reset = 0;
        tick();
        chk("t6_no_clr_after_reset", clr_cyc.size(), 0);
        clear_logs();
        tohost_we = 1; tohost_data = 32'h99AABBCC; fromhost_ack = 1; rx_valid = 1;
        for (int i = 0; i < 4; i++) begin
            rx_data = t6_rx[i];
            tick();
            tohost_we = 0;
        end
        rx_valid = 0;
        repeat (6) tick();
        fromhost_ack = 0;
        chk("t6_hs_count", hs_byte.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < hs_byte.size()) chk("t6_hs_byte", hs_byte[i], t6_bytes[i]);
        end
        chk("t6_clr_count", clr_cyc.size(), 1);
        chk("t6_fh_count", fh_log.size(), 1);
        if (fh_log.size() > 0) chk("t6_fh_word", fh_log[0], 32'h40302010);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset        = ($urandom_range(0, 299) == 0);
            tohost_we    = ($urandom_range(0, 5) == 0);
            tohost_data  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            tx_ready     = ($urandom_range(0, 3) != 0);
            rx_valid     = $urandom_range(0, 1) == 1;
            rx_data      = 8'($urandom);
            fromhost_ack = ($urandom_range(0, 2) == 0);
            tick();
        end

        reset = 0; tohost_we = 0; tx_ready = 1; rx_valid = 0; fromhost_ack = 1;
        repeat (20) tick();
        chk("drain_tx_empty", m_q.size(), 0);
        chk("drain_rx_idle", m_dlv, 1'b0);
        chk("drain_tx_valid", tx_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
